// File: rtl/gpu_ingress_queue_if.sv
// Handshake and status bundle between the GPU ingress queue and its surroundings.
// The slave modport is the queue's view; the master modport is the GPU/router side.
interface gpu_ingress_queue_if #(
  parameter int unsigned DWIDTH     = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned AWIDTH     = 6
) ();

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [DWIDTH-1:0] in_data;
  logic [AWIDTH-1:0] in_dest_addr;
  logic              in_valid;
  logic              in_ready;
  logic [DWIDTH-1:0] out_data;
  logic [AWIDTH-1:0] out_dest_addr;
  logic              out_valid;
  logic              out_ready;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [7:0]        drop_count;

  modport slave (
    input  in_data, in_dest_addr, in_valid, out_ready,
    output in_ready, out_data, out_dest_addr, out_valid,
    output fifo_full, fifo_empty, fifo_count, drop_count
  );

  modport master (
    output in_data, in_dest_addr, in_valid, out_ready,
    input  in_ready, out_data, out_dest_addr, out_valid,
    input  fifo_full, fifo_empty, fifo_count, drop_count
  );

endinterface

// File: rtl/gpu_ingress_queue.sv
// GPU-to-leaf-router ingress queue: circular buffer of {dest, data} flits
// followed by a single output register, with saturating drop accounting.
module gpu_ingress_queue #(
  parameter int unsigned DWIDTH     = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned AWIDTH     = 6
) (
  input  logic               clk,
  input  logic               reset,
  gpu_ingress_queue_if.slave q
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned EW = AWIDTH + DWIDTH;
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR  = PW'(FIFO_DEPTH - 1);
  localparam logic [7:0]    DROP_MAX  = 8'hFF;

  logic [EW-1:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              full_q;
  logic              empty_q;
  logic              ready_q;
  logic [7:0]        drops;
  logic              ovalid;
  logic [DWIDTH-1:0] odata;
  logic [AWIDTH-1:0] oaddr;

  logic              push_c;
  logic              pop_c;
  logic              drop_c;
  logic [CW-1:0]     count_nxt_c;
  logic [PW-1:0]     wr_ptr_nxt_c;
  logic [PW-1:0]     rd_ptr_nxt_c;

  // Handshake decisions use registered state only, so in_ready never sees out_ready.
  always_comb begin
    push_c       = 1'b0;
    pop_c        = 1'b0;
    drop_c       = 1'b0;
    count_nxt_c  = count;
    wr_ptr_nxt_c = wr_ptr;
    rd_ptr_nxt_c = rd_ptr;

    push_c = q.in_valid && !full_q;
    pop_c  = !empty_q && (!ovalid || q.out_ready);
    drop_c = q.in_valid && full_q && (drops != DROP_MAX);

    count_nxt_c = count + CW'(push_c) - CW'(pop_c);

    if (push_c) begin
      wr_ptr_nxt_c = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
    end
    if (pop_c) begin
      rd_ptr_nxt_c = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
    end
  end

  // Storage RAM carries no reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push_c && !reset) begin
      mem[wr_ptr] <= {q.in_dest_addr, q.in_data};
    end
  end

  // Occupancy, pointers and the status flags derived from the next count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ready_q <= 1'b1;
      drops   <= '0;
    end else begin
      wr_ptr  <= wr_ptr_nxt_c;
      rd_ptr  <= rd_ptr_nxt_c;
      count   <= count_nxt_c;
      full_q  <= (count_nxt_c == DEPTH_C);
      empty_q <= (count_nxt_c == '0);
      ready_q <= (count_nxt_c != DEPTH_C);
      if (drop_c) begin
        drops <= drops + 8'd1;
      end
    end
  end

  // Output register: refill from the head, otherwise retire a consumed flit.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovalid <= 1'b0;
      odata  <= '0;
      oaddr  <= '0;
    end else if (pop_c) begin
      ovalid         <= 1'b1;
      {oaddr, odata} <= mem[rd_ptr];
    end else if (q.out_ready) begin
      ovalid <= 1'b0;
    end
  end

  assign q.in_ready      = ready_q;
  assign q.out_data      = odata;
  assign q.out_dest_addr = oaddr;
  assign q.out_valid     = ovalid;
  assign q.fifo_full     = full_q;
  assign q.fifo_empty    = empty_q;
  assign q.fifo_count    = count;
  assign q.drop_count    = drops;

endmodule
